mb_xfer_seq: RTL and testbench

- Drive-side data-transfer sequencer on the slave side of the KS10 Massbus interface.
- Moves 36-bit words between a drive's local sector buffer and the RH11 using the mbREQO/mbACKI handshake.
- Drives mbINCWC, mbINCBA/mbDECBA and mbWCE; stops on mbWCZ or at end of sector.
- Disk/tape drive controllers instantiate it and arbitrate their sector buffer towards it.

---
 rtl/mb_xfer_pkg.sv | 23 ++
 rtl/mb_xfer_seq.sv | 191 +++++++++++++++++++
 tb/tb_mb_xfer_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_xfer_pkg.sv
// Shared types for the Massbus drive-side transfer sequencer.
package mb_xfer_pkg;

    localparam int DEF_WORDS = 128;

    typedef enum logic [1:0] {
        FN_READ,
        FN_WRITE,
        FN_WCHK,
        FN_NOP
    } xfer_func_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        REQ,
        STEP,
        CHECK,
        DONE
    } xfer_state_t;

endpackage

// File: rtl/mb_xfer_seq.sv
// Moves one sector of 36-bit words between the drive's buffer and the RH11
// over the mbREQO/mbACKI handshake, pulsing word-count and bus-address steps.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | buffer read strobe for buf_addr
// LATCH | capture buffer word (READ: mbDATAO, WCHK: compare register)
// REQ   | mbREQO held until mbACKI
// STEP  | mbINCWC + mbINCBA/mbDECBA (+ mbWCE) pulses, buffer write for WRITE
// CHECK | sample mbWCZ and end of sector, advance or finish
// DONE  | immediate completion (word count already zero or no-op function)
module mb_xfer_seq
    import mb_xfer_pkg::*;
#(
    parameter int WORDS = DEF_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    func,
    input  logic          rev,
    input  logic          abort,
    output logic [AW-1:0] buf_addr,
    output logic          buf_rd,
    input  logic [35:0]   buf_rdata,
    output logic          buf_wr,
    output logic [35:0]   buf_wdata,
    output logic          mbREQO,
    input  logic          mbACKI,
    output logic [35:0]   mbDATAO,
    input  logic [35:0]   mbDATAI,
    input  logic          mbWCZ,
    output logic          mbINCWC,
    output logic          mbINCBA,
    output logic          mbDECBA,
    output logic          mbWCE,
    output logic          mbNPRO,
    output logic          busy,
    output logic          sect_done,
    output logic          xfer_done
);

    xfer_state_t   state_q;
    xfer_func_t    func_q;
    logic          rev_q;
    logic          wce_seen_q;
    logic [AW-1:0] addr_q;
    logic [35:0]   dato_q;
    logic [35:0]   cmp_q;
    logic [35:0]   wdata_q;
    logic          rd_q, wr_q, req_q;
    logic          incwc_q, incba_q, decba_q, wce_q;
    logic          busy_q, npro_q, sdone_q, xdone_q;
    logic          last_word;

    assign last_word = (addr_q == AW'(WORDS - 1));

    // Completion pulses are registered out of CHECK/DONE, so they show up
    // in the first IDLE cycle together with busy dropping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            func_q     <= FN_READ;
            rev_q      <= 1'b0;
            wce_seen_q <= 1'b0;
            addr_q     <= '0;
            dato_q     <= '0;
            cmp_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            req_q      <= 1'b0;
            incwc_q    <= 1'b0;
            incba_q    <= 1'b0;
            decba_q    <= 1'b0;
            wce_q      <= 1'b0;
            busy_q     <= 1'b0;
            npro_q     <= 1'b0;
            sdone_q    <= 1'b0;
            xdone_q    <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            incwc_q <= 1'b0;
            incba_q <= 1'b0;
            decba_q <= 1'b0;
            wce_q   <= 1'b0;
            sdone_q <= 1'b0;
            xdone_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                req_q      <= 1'b0;
                busy_q     <= 1'b0;
                npro_q     <= 1'b0;
                wce_seen_q <= 1'b0;
                addr_q     <= '0;
                dato_q     <= '0;
                wdata_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            addr_q     <= '0;
                            func_q     <= xfer_func_t'(func);
                            rev_q      <= rev;
                            wce_seen_q <= 1'b0;
                            busy_q     <= 1'b0 | 1'b1;
                            npro_q     <= 1'b1;
                            if (mbWCZ || func == FN_NOP) begin
                                state_q <= DONE;
                            end else if (func == FN_WRITE) begin
                                state_q <= REQ;
                                req_q   <= 1'b1;
                            end else begin
                                state_q <= FETCH;
                                rd_q    <= 1'b1;
                            end
                        end
                    end
                    FETCH: state_q <= LATCH;
                    LATCH: begin
                        if (func_q == FN_READ) dato_q <= buf_rdata;
                        if (func_q == FN_WCHK) cmp_q  <= buf_rdata;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                    REQ: begin
                        if (mbACKI) begin
                            req_q   <= 1'b0;
                            incwc_q <= 1'b1;
                            incba_q <= ~rev_q;
                            decba_q <= rev_q;
                            if (func_q == FN_WRITE) begin
                                wr_q    <= 1'b1;
                                wdata_q <= mbDATAI;
                            end
                            if (func_q == FN_WCHK && cmp_q != mbDATAI) begin
                                wce_q      <= 1'b1;
                                wce_seen_q <= 1'b1;
                            end
                            state_q <= STEP;
                        end
                    end
                    STEP: state_q <= CHECK;
                    CHECK: begin
                        if (mbWCZ || wce_seen_q || last_word) begin
                            xdone_q <= mbWCZ | wce_seen_q;
                            sdone_q <= last_word;
                            busy_q  <= 1'b0;
                            npro_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                            if (func_q == FN_WRITE) begin
                                req_q   <= 1'b1;
                                state_q <= REQ;
                            end else begin
                                rd_q    <= 1'b1;
                                state_q <= FETCH;
                            end
                        end
                    end
                    DONE: begin
                        xdone_q <= 1'b1;
                        busy_q  <= 1'b0;
                        npro_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign buf_addr  = addr_q;
    assign buf_rd    = rd_q;
    assign buf_wr    = wr_q;
    assign buf_wdata = wdata_q;
    assign mbREQO    = req_q;
    assign mbDATAO   = dato_q;
    assign mbINCWC   = incwc_q;
    assign mbINCBA   = incba_q;
    assign mbDECBA   = decba_q;
    assign mbWCE     = wce_q;
    assign mbNPRO    = npro_q;
    assign busy      = busy_q;
    assign sect_done = sdone_q;
    assign xfer_done = xdone_q;

endmodule

// File: tb/tb_mb_xfer_seq.sv
// Directed bench for mb_xfer_seq with a 4-word buffer model and RH11 responder.
module tb_mb_xfer_seq;

    localparam int WORDS = 4;
    localparam int AW    = 2;
    localparam logic [35:0] DW = 36'o123456701234;
    localparam logic [35:0] XW = 36'o777000777000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    func = 2'd0;
    logic          rev = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] buf_addr;
    logic          buf_rd;
    logic [35:0]   buf_rdata;
    logic          buf_wr;
    logic [35:0]   buf_wdata;
    logic          mbREQO;
    logic          mbACKI;
    logic [35:0]   mbDATAO;
    logic [35:0]   mbDATAI = '0;
    logic          mbWCZ;
    logic          mbINCWC, mbINCBA, mbDECBA, mbWCE;
    logic          mbNPRO, busy, sect_done, xfer_done;

    mb_xfer_seq #(.WORDS(WORDS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .rev(rev), .abort(abort),
        .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_rdata(buf_rdata),
        .buf_wr(buf_wr), .buf_wdata(buf_wdata),
        .mbREQO(mbREQO), .mbACKI(mbACKI), .mbDATAO(mbDATAO), .mbDATAI(mbDATAI),
        .mbWCZ(mbWCZ), .mbINCWC(mbINCWC), .mbINCBA(mbINCBA), .mbDECBA(mbDECBA),
        .mbWCE(mbWCE), .mbNPRO(mbNPRO), .busy(busy),
        .sect_done(sect_done), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous read, data valid the cycle after buf_rd.
    logic [3:0][35:0] load_img = '0;
    logic             load_req = 1'b0;
    logic [35:0]      mem [WORDS];
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < WORDS; k++) mem[k] <= load_img[k];
        end else begin
            if (buf_rd) buf_rdata <= mem[buf_addr];
            if (buf_wr) mem[buf_addr] <= buf_wdata;
        end
    end

    // RH11 word count model: WCZ after wcz_limit INCWC pulses, or forced.
    logic wcz_force = 1'b0;
    int   wcz_limit = 0;
    int   wcz_base  = 0;
    int   ack_delay = 0;
    int   incwc_cnt = 0, incba_cnt = 0, decba_cnt = 0, wce_cnt = 0;
    int   xdone_cnt = 0, sdone_cnt = 0, req_cnt = 0, bufwr_cnt = 0;
    int   wce_at = 0, stab_err = 0, req_cyc = 0;
    logic prev_req = 1'b0;
    logic [35:0] prev_dato = '0;
    logic [35:0] data_log [64];

    assign mbWCZ = wcz_force || (wcz_limit != 0 && (incwc_cnt - wcz_base) >= wcz_limit);

    initial mbACKI = 1'b0;
    always @(negedge clk) begin
        incwc_cnt <= incwc_cnt + int'(mbINCWC);
        incba_cnt <= incba_cnt + int'(mbINCBA);
        decba_cnt <= decba_cnt + int'(mbDECBA);
        wce_cnt   <= wce_cnt + int'(mbWCE);
        xdone_cnt <= xdone_cnt + int'(xfer_done);
        sdone_cnt <= sdone_cnt + int'(sect_done);
        bufwr_cnt <= bufwr_cnt + int'(buf_wr);
        if (mbWCE) wce_at <= incwc_cnt + int'(mbINCWC);
        if (mbREQO && !prev_req) begin
            if (req_cnt < 64) data_log[req_cnt] <= mbDATAO;
            req_cnt <= req_cnt + 1;
        end
        if (mbREQO && prev_req && mbDATAO != prev_dato) stab_err <= stab_err + 1;
        prev_req  <= mbREQO;
        prev_dato <= mbDATAO;
        if (mbREQO) begin
            mbACKI  = (req_cyc == ack_delay);
            req_cyc <= req_cyc + 1;
        end else begin
            mbACKI  = 1'b0;
            req_cyc <= 0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_fail++;
            n_checks++;
            $display("FAIL %s: busy still %0d after %0d cycles, expected 0", name, busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic load(input logic [3:0][35:0] img);
        @(negedge clk);
        load_img = img;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]       func;
        logic             rev;
        logic             wcz_force;
        logic [3:0]       wcz_limit;
        logic [3:0]       ack_delay;
        logic [35:0]      datai;
        logic [3:0][35:0] img;
        logic [3:0][35:0] exp_img;
        logic [3:0]       e_incwc, e_incba, e_decba, e_wce;
        logic [3:0]       e_xdone, e_sdone, e_reqs, e_bufwr;
    } vec_t;

    vec_t vecs [7];

    int b_incwc, b_incba, b_decba, b_wce, b_xdone, b_sdone, b_req, b_bufwr;

    task automatic snap();
        b_incwc = incwc_cnt; b_incba = incba_cnt; b_decba = decba_cnt; b_wce = wce_cnt;
        b_xdone = xdone_cnt; b_sdone = sdone_cnt; b_req = req_cnt; b_bufwr = bufwr_cnt;
    endtask

    initial begin
        logic [3:0][35:0] seq_img;
        logic [3:0][35:0] dimg;
        int n;
        seq_img = {36'd4, 36'd3, 36'd2, 36'd1};
        dimg    = {DW, DW, DW, DW};
        vecs[0] = '{2'd0, 1'b0, 1'b0, 4'd0, 4'd2, 36'd0, seq_img, seq_img,
                    4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd0};
        vecs[1] = '{2'd1, 1'b1, 1'b0, 4'd2, 4'd1, DW,
                    {36'd14, 36'd13, 36'd12, 36'd11}, {36'd14, 36'd13, DW, DW},
                    4'd2, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0, 4'd2, 4'd2};
        vecs[2] = '{2'd2, 1'b0, 1'b0, 4'd0, 4'd0, DW, {DW, XW, DW, DW}, {DW, XW, DW, DW},
                    4'd3, 4'd3, 4'd0, 4'd1, 4'd1, 4'd0, 4'd3, 4'd0};
        vecs[3] = '{2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 36'd0, seq_img, seq_img,
                    4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        vecs[4] = '{2'd3, 1'b0, 1'b0, 4'd0, 4'd0, 36'd0, seq_img, seq_img,
                    4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        vecs[5] = '{2'd2, 1'b1, 1'b0, 4'd0, 4'd0, DW, dimg, dimg,
                    4'd4, 4'd0, 4'd4, 4'd0, 4'd0, 4'd1, 4'd4, 4'd0};
        vecs[6] = '{2'd1, 1'b0, 1'b0, 4'd4, 4'd0, XW, seq_img, {XW, XW, XW, XW},
                    4'd4, 4'd4, 4'd0, 4'd0, 4'd1, 4'd1, 4'd4, 4'd4};

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_reqo", 64'(mbREQO), 64'd0);
        check("reset_addr", 64'(buf_addr), 64'd0);
        check("reset_dato", 64'(mbDATAO), 64'd0);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].img);
            func      = vecs[v].func;
            rev       = vecs[v].rev;
            mbDATAI   = vecs[v].datai;
            wcz_force = vecs[v].wcz_force;
            wcz_base  = incwc_cnt;
            wcz_limit = int'(vecs[v].wcz_limit);
            ack_delay = int'(vecs[v].ack_delay);
            @(negedge clk);
            snap();
            pulse_start();
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
            wait_idle($sformatf("v%0d_idle", v));
            check($sformatf("v%0d_incwc", v), 64'(incwc_cnt - b_incwc), 64'(vecs[v].e_incwc));
            check($sformatf("v%0d_incba", v), 64'(incba_cnt - b_incba), 64'(vecs[v].e_incba));
            check($sformatf("v%0d_decba", v), 64'(decba_cnt - b_decba), 64'(vecs[v].e_decba));
            check($sformatf("v%0d_wce", v), 64'(wce_cnt - b_wce), 64'(vecs[v].e_wce));
            check($sformatf("v%0d_xdone", v), 64'(xdone_cnt - b_xdone), 64'(vecs[v].e_xdone));
            check($sformatf("v%0d_sdone", v), 64'(sdone_cnt - b_sdone), 64'(vecs[v].e_sdone));
            check($sformatf("v%0d_reqs", v), 64'(req_cnt - b_req), 64'(vecs[v].e_reqs));
            check($sformatf("v%0d_bufwr", v), 64'(bufwr_cnt - b_bufwr), 64'(vecs[v].e_bufwr));
            for (int k = 0; k < WORDS; k++)
                check($sformatf("v%0d_mem%0d", v, k), 64'(mem[k]), 64'(vecs[v].exp_img[k]));
            if (vecs[v].func == 2'd0) begin
                for (int k = 0; k < int'(vecs[v].e_reqs); k++)
                    check($sformatf("v%0d_dato%0d", v, k), 64'(data_log[b_req + k]),
                          64'(vecs[v].img[k]));
            end
            if (vecs[v].e_wce != 4'd0)
                check($sformatf("v%0d_wce_at", v), 64'(wce_at - b_incwc), 64'(vecs[v].e_reqs));
        end

        // Immediate completion: xfer_done exactly two cycles after start.
        for (int t = 0; t < 2; t++) begin
            func      = (t == 0) ? 2'd3 : 2'd0;
            wcz_force = (t == 1);
            wcz_limit = 0;
            @(negedge clk);
            snap();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("imm%0d_done_c1", t), 64'(xfer_done), 64'd0);
            @(negedge clk);
            check($sformatf("imm%0d_done_c2", t), 64'(xfer_done), 64'd1);
            repeat (3) @(negedge clk);
            check($sformatf("imm%0d_reqs", t), 64'(req_cnt - b_req), 64'd0);
        end
        wcz_force = 1'b0;

        // Abort coinciding with ACKI during a WRITE request.
        load({36'd4, 36'd3, 36'd2, 36'd1});
        func = 2'd1; rev = 1'b0; mbDATAI = DW; ack_delay = 1;
        @(negedge clk);
        snap();
        pulse_start();
        n = 0;
        while (!mbREQO && n < 20) begin @(negedge clk); n++; end
        check("abort_req_seen", 64'(mbREQO), 64'd1);
        @(negedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_reqo", 64'(mbREQO), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_npro", 64'(mbNPRO), 64'd0);
        check("abort_bufwr", 64'(buf_wr), 64'd0);
        check("abort_incwc", 64'(mbINCWC), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_bufwr_cnt", 64'(bufwr_cnt - b_bufwr), 64'd0);
        check("abort_incwc_cnt", 64'(incwc_cnt - b_incwc), 64'd0);
        check("abort_done_cnt", 64'(xdone_cnt - b_xdone + sdone_cnt - b_sdone), 64'd0);
        check("abort_mem1", 64'(mem[1]), 64'd2);

        // Asynchronous reset in the middle of the second READ request.
        func = 2'd0; ack_delay = 2;
        @(negedge clk);
        snap();
        pulse_start();
        n = 0;
        while (!(mbREQO && (req_cnt - b_req) >= 2) && n < 60) begin @(negedge clk); n++; end
        check("rst_req_addr", 64'(buf_addr), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_async_reqo", 64'(mbREQO), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_addr", 64'(buf_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        snap();
        pulse_start();
        check("rst_restart_addr", 64'(buf_addr), 64'd0);
        n = 0;
        while (!mbREQO && n < 20) begin @(negedge clk); n++; end
        check("rst_restart_dato", 64'(mbDATAO), 64'd1);
        wait_idle("rst_restart_idle");
        check("rst_restart_sdone", 64'(sdone_cnt - b_sdone), 64'd1);

        check("dato_stable", 64'(stab_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
